// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio -- receive half of the SoC UART with a processor read port.
//
// Deserialises 8N1 frames from ip_rx into a small FIFO and answers reads in
// the UART address window (the SoC decodes data_addr[31] into ip_sel).
//   offset 0x0 DATA   : {valid, 23'b0, head_byte}; pops the FIFO when non-empty
//   offset 0x4 STATUS : bit0 not_empty, bit1 full, bit2 overrun, bit3 frame_err,
//                       bit4 parity_err, bits[12:8] count; bits 2..4 clear on read
//   other offsets read 0. Writes are handled by the transmit side.
//
// Optional feature: define UART_RX_PARITY_EN to expect an even parity bit
// between the last data bit and the stop bit (8E1 framing).
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-low reset
//   ip_rx           serial line, idle high, asynchronous to clk
//   ip_sel          UART window access
//   ip_data_addr    byte offset within the window
//   ip_data_rd      processor read strobe
//   op_data_valid   read response valid (combinational, same cycle)
//   op_data_to_proc read data, 0 when op_data_valid is low
module uart_rx_mmio #(
   parameter int CLKS_PER_BIT = 16,  // >= 4 and even
   parameter int FIFO_DEPTH   = 4    // power of 2, 2..16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ip_rx,
   input  logic        ip_sel,
   input  logic [2:0]  ip_data_addr,
   input  logic        ip_data_rd,
   output logic        op_data_valid,
   output logic [31:0] op_data_to_proc
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] MID_CNT  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

   state_t          state, state_next;
   logic            rx_meta, rx_sync;
   logic [CW-1:0]   cnt, cnt_next;
   logic [2:0]      idx, idx_next;
   logic [7:0]      shift, shift_next;
   logic            push, frame_set, parity_set;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [4:0]      count;
   logic            not_empty, full, pop, push_ok;
   logic            rd_data, rd_status;
   logic            overrun, frame_err, parity_flag;

   // Two-flop synchroniser; reset to the idle line level so no false start.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= ip_rx;
         rx_sync <= rx_meta;
      end
   end

   // Receiver FSM state register and bit-timing datapath.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         idx   <= idx_next;
         shift <= shift_next;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bad, par_bad_next;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) par_bad <= 1'b0;
      else        par_bad <= par_bad_next;
   end
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_next = state;
      cnt_next   = cnt + CW'(1);
      idx_next   = idx;
      shift_next = shift;
      push       = 1'b0;
      frame_set  = 1'b0;
      parity_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_next = par_bad;
`endif
      case (state)
         S_IDLE: begin
            cnt_next = '0;
            if (!rx_sync) state_next = S_START;
         end
         S_START: begin
            // Re-check the line at mid start bit to reject glitches.
            if (cnt == MID_CNT) begin
               cnt_next = '0;
               if (!rx_sync) begin
                  state_next = S_DATA;
                  idx_next   = '0;
               end else begin
                  state_next = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (cnt == LAST_CNT) begin
               cnt_next   = '0;
               shift_next = {rx_sync, shift[7:1]};  // LSB arrives first
               idx_next   = idx + 3'd1;
               if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_next = S_PARITY;
`else
                  state_next = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt == LAST_CNT) begin
               cnt_next     = '0;
               par_bad_next = ^{shift, rx_sync};  // even parity: XOR must be 0
               parity_set   = ^{shift, rx_sync};
               state_next   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt == LAST_CNT) begin
               cnt_next = '0;
               if (rx_sync) begin
`ifdef UART_RX_PARITY_EN
                  push = ~par_bad;
`else
                  push = 1'b1;
`endif
                  state_next = S_IDLE;
               end else begin
                  frame_set  = 1'b1;
                  state_next = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            // Line held low past the stop bit: wait for idle before re-arming.
            cnt_next = '0;
            if (rx_sync) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Read decode.
   assign op_data_valid = ip_sel & ip_data_rd;
   assign rd_data       = op_data_valid & (ip_data_addr == 3'h0);
   assign rd_status     = op_data_valid & (ip_data_addr == 3'h4);

   assign not_empty = (count != 5'd0);
   assign full      = (count == 5'(FIFO_DEPTH));
   assign pop       = rd_data & not_empty;
   // A pop in the same cycle frees a slot, so a push into a full FIFO succeeds.
   assign push_ok   = push & (~full | pop);

   // NOTE: FIFO storage has no reset; an entry is only visible once written,
   // and the read mux masks the head byte while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= shift;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + 5'd1;
            2'b01:   count <= count - 5'd1;
            default: count <= count;
         endcase
         // A sticky event in the clearing read cycle keeps the flag set.
         overrun   <= (push & ~push_ok) | (overrun   & ~rd_status);
         frame_err <= frame_set         | (frame_err & ~rd_status);
      end
   end

`ifdef UART_RX_PARITY_EN
   logic parity_err;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) parity_err <= 1'b0;
      else        parity_err <= parity_set | (parity_err & ~rd_status);
   end
   assign parity_flag = parity_err;
`else
   assign parity_flag = parity_set;  // constant 0 in 8N1 builds
`endif

   always_comb begin
      op_data_to_proc = 32'h0;
      if (op_data_valid) begin
         case (ip_data_addr)
            3'h0: op_data_to_proc = {not_empty, 23'b0, not_empty ? mem[rd_ptr] : 8'h00};
            3'h4: op_data_to_proc = {19'b0, count, 3'b0, parity_flag, frame_err,
                                     overrun, full, not_empty};
            default: op_data_to_proc = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio: directed scenarios followed by random
// frames, all compared against a queue-based model of the receive FIFO and
// sticky flags.
module tb_uart_rx_mmio;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        ip_rx;
   logic        ip_sel;
   logic [2:0]  ip_data_addr;
   logic        ip_data_rd;
   logic        op_data_valid;
   logic [31:0] op_data_to_proc;

   int checks = 0;
   int errors = 0;

   logic [7:0] model_q[$];
   logic       m_ovr, m_ferr, m_perr;

   uart_rx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset           (reset),
      .ip_rx           (ip_rx),
      .ip_sel          (ip_sel),
      .ip_data_addr    (ip_data_addr),
      .ip_data_rd      (ip_data_rd),
      .op_data_valid   (op_data_valid),
      .op_data_to_proc (op_data_to_proc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      int n = model_q.size();
      return {19'b0, 5'(n), 3'b0, m_perr, m_ferr, m_ovr, (n == DEPTH), (n != 0)};
   endfunction

   task automatic model_reset();
      model_q.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      m_perr = 1'b0;
   endtask

   // All bus tasks start and end on a falling edge.
   task automatic bus_read(input logic [2:0] addr, output logic [31:0] data,
                           output logic valid);
      ip_sel = 1'b1; ip_data_rd = 1'b1; ip_data_addr = addr;
      #1;
      data  = op_data_to_proc;
      valid = op_data_valid;
      @(negedge clk);
      ip_sel = 1'b0; ip_data_rd = 1'b0; ip_data_addr = 3'h0;
   endtask

   task automatic read_status(input string tag);
      logic [31:0] exp, got;
      logic        v;
      exp = exp_status();
      bus_read(3'h4, got, v);
      check(tag, got, exp);
      check({tag, "_valid"}, {31'b0, v}, 32'd1);
      m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
   endtask

   // Holds the DATA read strobe for n consecutive cycles.
   task automatic read_data_burst(input string tag, input int n);
      logic [31:0] exp;
      ip_sel = 1'b1; ip_data_rd = 1'b1; ip_data_addr = 3'h0;
      for (int i = 0; i < n; i++) begin
         #1;
         if (model_q.size() != 0) exp = {1'b1, 23'b0, model_q[0]};
         else                     exp = 32'h0;
         check($sformatf("%s_%0d", tag, i), op_data_to_proc, exp);
         check($sformatf("%s_%0d_valid", tag, i), {31'b0, op_data_valid}, 32'd1);
         if (model_q.size() != 0) model_q.delete(0);
         @(negedge clk);
      end
      ip_sel = 1'b0; ip_data_rd = 1'b0;
   endtask

   task automatic drive_bit(input logic v);
      ip_rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^b) ^ !par_ok);
      if (!par_ok) m_perr = 1'b1;
`endif
      drive_bit(stop_ok);
      if (!stop_ok) m_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
      if (stop_ok && par_ok) begin
`else
      if (stop_ok) begin
`endif
         if (model_q.size() < DEPTH) model_q.push_back(b);
         else                        m_ovr = 1'b1;
      end
      ip_rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   initial begin
      logic [31:0] got;
      logic        v;
      logic [7:0]  b;
      bit          stop_ok, par_ok;

      reset = 1'b0; ip_rx = 1'b1;
      ip_sel = 1'b0; ip_data_rd = 1'b0; ip_data_addr = 3'h0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Reset state and idle bus behaviour.
      check("idle_valid", {31'b0, op_data_valid}, 32'd0);
      check("idle_data", op_data_to_proc, 32'h0);
      ip_sel = 1'b1; #1;
      check("sel_no_rd_valid", {31'b0, op_data_valid}, 32'd0);
      check("sel_no_rd_data", op_data_to_proc, 32'h0);
      ip_sel = 1'b0; ip_data_rd = 1'b1; #1;
      check("rd_no_sel_valid", {31'b0, op_data_valid}, 32'd0);
      @(negedge clk); ip_data_rd = 1'b0;
      read_status("reset_status");

      // Single byte.
      send_frame(8'h55, 1'b1, 1'b1);
      read_status("t1_status");
      read_data_burst("t1_data", 1);
      read_status("t1_status_after");

      // Overrun: five bytes into four entries, then drain past empty.
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
      read_status("t2_status_full");
      read_data_burst("t2_drain", DEPTH + 1);
      read_status("t2_status_drained");
      bus_read(3'h2, got, v);
      check("unmapped_offset", got, 32'h0);
      check("unmapped_valid", {31'b0, v}, 32'd1);

      // Framing error, then recovery.
      send_frame(8'hA3, 1'b0, 1'b1);
      read_status("t3_frame_err");
      send_frame(8'h3C, 1'b1, 1'b1);
      read_data_burst("t3_data", 1);

      // Short glitch on the line must not start a frame.
      ip_rx = 1'b0;
      repeat (4) @(negedge clk);
      ip_rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      read_status("t4_glitch");

      // Reset in the middle of a frame, with a byte already buffered.
      send_frame(8'h11, 1'b1, 1'b1);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      repeat (CPB / 2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      ip_rx = 1'b1;
      reset = 1'b1;
      repeat (CPB) @(negedge clk);
      read_status("t5_after_reset");
      send_frame(8'h7E, 1'b1, 1'b1);
      read_status("t5_status");
      read_data_burst("t5_data", 2);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0);
      read_status("t6_parity_err");
      send_frame(8'h07, 1'b1, 1'b1);
      read_data_burst("t6_data", 1);
`endif

      // Random frames with interleaved reads.
      for (int k = 0; k < 16; k++) begin
         b       = 8'($urandom);
         stop_ok = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
         par_ok  = ($urandom_range(0, 5) != 0);
`else
         par_ok  = 1'b1;
`endif
         send_frame(b, stop_ok, par_ok);
         if ($urandom_range(0, 2) == 0) read_status($sformatf("rnd%0d_status", k));
         if ($urandom_range(0, 1) == 0)
            read_data_burst($sformatf("rnd%0d_data", k), int'($urandom_range(1, 3)));
      end
      read_status("final_status");
      read_data_burst("final_drain", DEPTH + 1);
      read_status("final_status_empty");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_mmio.md
Name: uart_rx_mmio

Overview:
- Receive side of the SoC UART: deserialises 8N1 bytes from a serial input line into a small FIFO.
- Answers processor MMIO reads in the UART address window (data_addr[31] set) with received bytes and status.
- Replaces the constant read value currently returned for UART reads.
- Sits beside dmem on the processor data port; the SoC routes ip_sel/ip_data_rd to it and muxes op_data_to_proc back.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 4 and even.
FIFO_DEPTH, 4, receive FIFO entries; power of 2, 2..16.

Ports:
clk  input  1  system clock
reset  input  1  one clock; reset is asynchronous and active-low
ip_rx  input  1  serial line, idle high, asynchronous to clk
ip_sel  input  1  UART window access (data_addr[31])
ip_data_addr  input  3  byte offset within window: 0x0 DATA, 0x4 STATUS; others read 0
ip_data_rd  input  1  processor read strobe
op_data_valid  output  1  read response valid
op_data_to_proc  output  32  read data

Behaviour:
- Reset (reset low, async): FSM to IDLE, FIFO empty (count 0, pointers 0), sticky flags 0, synchroniser flops 1, bit/clock counters 0. Reset mid-frame discards the partial byte.
- Two-flop synchroniser on ip_rx; all FSM decisions use the synchronised value.
- IDLE: on synchronised rx low, go to START with clock counter 0.
- START: at count CLKS_PER_BIT/2-1 (mid start bit), sample.
  - Low: go to DATA, counter 0, bit index 0.
  - High (glitch): return to IDLE; nothing pushed.
- DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first, shifted into a byte register. After bit 7, go to STOP (or PARITY when the feature is enabled).
- STOP: sample after CLKS_PER_BIT cycles.
  - High: push byte, go to IDLE.
  - Low: set frame_err sticky, discard byte, go to BREAK.
- BREAK: wait for synchronised rx high, then IDLE.
- Push into a full FIFO: byte dropped, overrun sticky set, existing contents unchanged. Exception: a pop in the same cycle makes room, so the push succeeds.
- Reads:
  - op_data_valid = ip_sel & ip_data_rd, combinational, zero latency (matches the dmem read timing).
  - op_data_to_proc is 0 whenever op_data_valid is 0.
- DATA read:
  - Returns {valid, 23'b0, head_byte}; valid=1 when FIFO non-empty.
  - If non-empty, the FIFO pops on the clk edge ending the read cycle.
  - If empty, returns 0x0000_0000 and does not pop.
  - A read strobe held N cycles pops N entries (one per cycle).
- STATUS read:
  - Bit fields: bit0 not_empty, bit1 full, bit2 overrun, bit3 frame_err, bit4 parity_err, bits[12:8] count (5 bits), others 0.
  - Sticky bits 2..4 clear on the clk edge ending the read cycle.
  - A sticky event in that same cycle wins: the flag stays set.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH; full when count==FIFO_DEPTH.
- No write path: writes to the window are transmit-side and ignored here.

Optional Feature:
UART_RX_PARITY_EN:
- Defined: FSM inserts a PARITY state after DATA, sampling one bit CLKS_PER_BIT later.
  - Even parity over the 8 data bits plus the parity bit must be 0.
  - On mismatch, parity_err sticky is set; the byte is discarded even if the stop bit is good.
- Undefined: 8N1 only, no PARITY state, STATUS bit4 reads 0.

Test Plan:
1. CLKS_PER_BIT=16, send 0x55 8N1.
   - Before the byte: STATUS reads 0x0000_0000.
   - About 10 bit times after start: STATUS reads 0x0000_0101.
   - DATA read returns 0x8000_0055; next STATUS reads 0x0000_0000.
2. FIFO_DEPTH=4, send 0x01..0x05 with no reads.
   - STATUS reads 0x0000_0407.
   - DATA reads return 0x8000_0001..0x8000_0004, then 0x0000_0000; overrun clears after the STATUS read.
3. Send 0xA3 with stop bit forced low, then line high.
   - STATUS reads 0x0000_0008; no byte stored.
   - The following byte 0x3C is received correctly.
4. Pull rx low for 4 clk cycles only.
   - STATUS stays 0x0000_0000, FSM back to IDLE.
5. Assert reset mid-byte (bit 4 of 0xFF), deassert, send 0x7E.
   - Only 0x7E is received; count=1.
6. With UART_RX_PARITY_EN, send 0x07 with parity bit 0 (wrong; 3 ones).
   - STATUS reads 0x0000_0010.
   - Resend with parity 1 and DATA reads 0x8000_0007.
